// File: rtl/simon_pkg.sv
// Shared Simon definitions: playback FSM state codes and width helpers,
// used by the playback reader, the sequence stack and the game controller.
package simon_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FETCH = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_TONE  = 3'd3;
    localparam state_t ST_GAP   = 3'd4;
    localparam state_t ST_FIN   = 3'd5;

    localparam int MAX_SHIFT = 3;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int len_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Tone length after the speed-up shift, never shorter than one clock.
    function automatic int tone_len(input int cycles, input int shift);
        int t;
        t = cycles >> shift;
        return (t < 1) ? 1 : t;
    endfunction

endpackage

// File: rtl/simon_playback_if.sv
// Playback bus: game-control command/status plus the sequence RAM read port
// and the oscillator note outputs.
interface simon_playback_if
    import simon_pkg::*;
#(
    parameter int DATA_WIDTH = 2,
    parameter int DEPTH      = 16
);
    localparam int ADDR_W = addr_w(DEPTH);
    localparam int LEN_W  = len_w(DEPTH);

    logic                  start;
    logic                  abort;
    logic [LEN_W-1:0]      seq_len;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] note_sel;
    logic                  note_on;
    logic                  busy;
    logic                  done;

    modport master (
        output start, abort, seq_len, rd_data,
        input  rd_en, rd_addr, note_sel, note_on, busy, done
    );

    modport slave (
        input  start, abort, seq_len, rd_data,
        output rd_en, rd_addr, note_sel, note_on, busy, done
    );

endinterface

// File: rtl/simon_timer.sv
// Loadable down-counter shared by the TONE and GAP phases; zero flags the
// last cycle of the current phase.
module simon_timer #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);
    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              count <= '0;
        else if (load)           count <= value;
        else if (count != '0)    count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/simon_playback.sv
// Simon sequence playback: reads entries 0..len-1 from a 1-cycle-latency RAM and
// plays each as a timed tone followed by a gap. Optional macro: SIMON_SPEEDUP_EN.
module simon_playback
    import simon_pkg::*;
#(
    parameter int DATA_WIDTH  = 2,
    parameter int DEPTH       = 16,
    parameter int TONE_CYCLES = 1000000,
    parameter int GAP_CYCLES  = 250000
) (
    input  logic           clk,
    input  logic           rst_n,
    simon_playback_if.slave bus
);
    localparam int ADDR_W = addr_w(DEPTH);
    localparam int LEN_W  = len_w(DEPTH);
    localparam int T_MAX  = (TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES;
    localparam int TW     = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    state_t                state, state_nx;
    logic [ADDR_W-1:0]     index;
    logic [LEN_W-1:0]      len;
    logic [LEN_W-1:0]      len_clamped;
    logic [DATA_WIDTH-1:0] note_sel_q;
    logic                  tmr_load, tmr_zero, last_entry, accept;
    logic [TW-1:0]         tmr_value, tone_load;

    assign len_clamped = (bus.seq_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : bus.seq_len;
    assign accept      = (state == ST_IDLE) && bus.start && !bus.abort;
    assign last_entry  = (LEN_W'(index) == len - LEN_W'(1));

`ifdef SIMON_SPEEDUP_EN
    // Shift is frozen at START so the tone length stays constant within one playback.
    logic [1:0]       shift_q;
    logic [LEN_W-1:0] len_q4;
    assign len_q4    = len_clamped >> 2;
    assign tone_load = TW'(tone_len(TONE_CYCLES, int'(shift_q)) - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      shift_q <= '0;
        else if (accept) shift_q <= (len_q4 > LEN_W'(MAX_SHIFT)) ? 2'(MAX_SHIFT) : 2'(len_q4);
    end
`else
    assign tone_load = TW'(TONE_CYCLES - 1);
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        tmr_load  = 1'b0;
        tmr_value = '0;
        if (state != ST_IDLE && bus.abort) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (accept) state_nx = (len_clamped == '0) ? ST_FIN : ST_FETCH;
                ST_FETCH: state_nx = ST_WAIT;
                ST_WAIT: begin
                    state_nx  = ST_TONE;
                    tmr_load  = 1'b1;
                    tmr_value = tone_load;
                end
                ST_TONE: if (tmr_zero) begin
                    state_nx  = ST_GAP;
                    tmr_load  = 1'b1;
                    tmr_value = TW'(GAP_CYCLES - 1);
                end
                ST_GAP:   if (tmr_zero) state_nx = last_entry ? ST_FIN : ST_FETCH;
                ST_FIN:   state_nx = ST_IDLE;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            index      <= '0;
            len        <= '0;
            note_sel_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                index <= '0;
                len   <= len_clamped;
            end
            if (state == ST_WAIT && !bus.abort)
                note_sel_q <= bus.rd_data;
            if (state == ST_GAP && tmr_zero && !bus.abort && !last_entry)
                index <= index + 1'b1;
        end
    end

    simon_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .value (tmr_value),
        .zero  (tmr_zero)
    );

    assign bus.rd_en    = (state == ST_FETCH);
    assign bus.rd_addr  = index;
    assign bus.note_sel = note_sel_q;
    assign bus.note_on  = (state == ST_TONE);
    assign bus.busy     = (state == ST_FETCH) || (state == ST_WAIT) ||
                          (state == ST_TONE)  || (state == ST_GAP);
    assign bus.done     = (state == ST_FIN);

endmodule

// File: tb/tb_simon_playback.sv
// Self-checking bench for simon_playback: scoreboard of expected read addresses
// and notes, tone width / period / DONE timing checks. Honors SIMON_SPEEDUP_EN.
module tb_simon_playback;

    localparam int DW    = 2;
    localparam int DEPTH = 16;
    localparam int TONE  = 4;
    localparam int GAP   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    simon_playback_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    simon_playback #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .TONE_CYCLES (TONE),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Sequence RAM model: data valid only in the cycle after the read strobe.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
        else           bus.rd_data <= 'x;
    end

    int n_checks = 0;
    int n_errors = 0;
    int rel, n_reads, n_tones, n_done, done_rel, first_on_rel, on_w, last_w, last_rd_rel;
    int exp_width, exp_period;
    bit width_chk;
    logic prev_on = 1'b0;
    int            exp_addr [$];
    logic [DW-1:0] exp_note [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp_len(input int len);
        return (len > DEPTH) ? DEPTH : len;
    endfunction

    function automatic int tone_w(input int len);
        int w;
        w = TONE;
`ifdef SIMON_SPEEDUP_EN
        begin
            int sh;
            sh = len / 4;
            if (sh > 3) sh = 3;
            w = TONE >> sh;
            if (w < 1) w = 1;
        end
`endif
        return w;
    endfunction

    // One clock; observe outputs 1 time unit after the edge and score them.
    task automatic tick();
        @(posedge clk);
        #1;
        rel++;
        if (bus.rd_en) begin
            n_reads++;
            if (n_reads > 1) check("rd_period", rel - last_rd_rel, exp_period);
            last_rd_rel = rel;
            if (exp_addr.size() != 0) check("rd_addr", bus.rd_addr, exp_addr.pop_front());
            else                      check("extra_rd_en", bus.rd_en, 1'b0);
        end
        if (bus.note_on && !prev_on) begin
            n_tones++;
            if (first_on_rel < 0) first_on_rel = rel;
            on_w = 0;
            if (exp_note.size() != 0) check("note_sel", bus.note_sel, exp_note.pop_front());
            else                      check("extra_tone", bus.note_on, 1'b0);
        end
        if (bus.note_on) on_w++;
        if (!bus.note_on && prev_on) begin
            last_w = on_w;
            if (width_chk) check("tone_width", on_w, exp_width);
        end
        if (bus.done) begin
            n_done++;
            done_rel = rel;
            check("busy_in_fin", bus.busy, 1'b0);
        end
        prev_on = bus.note_on;
    endtask

    // Drive one START cycle and push the expected reads/notes onto the scoreboard.
    task automatic start_play(input int len);
        int cl;
        cl = clamp_len(len);
        exp_addr.delete();
        exp_note.delete();
        for (int i = 0; i < cl; i++) begin
            exp_addr.push_back(i);
            exp_note.push_back(mem[i]);
        end
        rel = 0; n_reads = 0; n_tones = 0; first_on_rel = -1; done_rel = -1; last_rd_rel = 0;
        exp_width  = tone_w(cl);
        exp_period = 2 + exp_width + GAP;
        width_chk  = 1'b1;
        bus.start   = 1'b1;
        bus.seq_len = 5'(len);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n0;
        n0 = n_done;
        for (int i = 0; i < budget && n_done == n0; i++) tick();
        check("done_seen", n_done - n0, 1);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.seq_len = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom_range(0, 3));
        mem[0] = 2'd2; mem[1] = 2'd1; mem[2] = 2'd3;

        // 1: reset held with START high
        bus.start = 1'b1;
        repeat (3) tick();
        check("rst_rd_en",    bus.rd_en,    1'b0);
        check("rst_rd_addr",  bus.rd_addr,  4'd0);
        check("rst_note_sel", bus.note_sel, 2'd0);
        check("rst_note_on",  bus.note_on,  1'b0);
        check("rst_busy",     bus.busy,     1'b0);
        check("rst_done",     bus.done,     1'b0);
        bus.start = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", bus.busy, 1'b0);

        // 2: three-entry playback, timing of reads, tones and DONE
        start_play(3);
        wait_done(100);
        check("t2_done_rel",  done_rel, 3 * exp_period + 1);
        check("t2_first_on",  first_on_rel, 3);
        check("t2_reads",     n_reads, 3);
        check("t2_tones",     n_tones, 3);
        check("t2_addr_left", exp_addr.size(), 0);
        tick();
        check("t2_done_pulse", bus.done, 1'b0);

        // ABORT together with START in IDLE: stays idle
        bus.abort = 1'b1; bus.start = 1'b1; bus.seq_len = 5'd3;
        tick();
        bus.abort = 1'b0; bus.start = 1'b0;
        check("abort_start_busy", bus.busy,  1'b0);
        check("abort_start_rd",   bus.rd_en, 1'b0);

        // 3: zero-length sequence
        start_play(0);
        check("t3_done_rel", done_rel, 1);
        check("t3_reads",    n_reads, 0);
        tick();
        check("t3_tones",    n_tones, 0);

        // 4: length clamp, no address wrap
        start_play(20);
        wait_done(200);
        check("t4_reads",     n_reads, DEPTH);
        check("t4_addr_left", exp_addr.size(), 0);
        check("t4_done_rel",  done_rel, DEPTH * exp_period + 1);
        tick();

        // 5: abort during second tone, then restart from address 0
        start_play(3);
        for (int i = 0; i < 100 && n_tones < 2; i++) tick();
        check("t5_tone2", n_tones, 2);
        width_chk = 1'b0;
        n0 = n_done;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("t5_note_on", bus.note_on, 1'b0);
        check("t5_busy",    bus.busy,    1'b0);
        check("t5_rd_en",   bus.rd_en,   1'b0);
        repeat (30) tick();
        check("t5_no_done", n_done - n0, 0);
        start_play(1);
        wait_done(50);
        check("t5_restart_reads", n_reads, 1);
        check("t5_restart_left",  exp_addr.size(), 0);
        tick();

        // 6: START ignored during TONE and in FIN
        start_play(2);
        for (int i = 0; i < 50 && n_tones < 1; i++) tick();
        bus.start = 1'b1; bus.seq_len = 5'd5;
        tick();
        bus.start = 1'b0;
        wait_done(100);
        check("t6_done_rel", done_rel, 2 * exp_period + 1);
        check("t6_reads",    n_reads, 2);
        bus.start = 1'b1; bus.seq_len = 5'd3;
        tick();
        bus.start = 1'b0;
        check("t6_fin_start_busy", bus.busy, 1'b0);
        tick();
        check("t6_fin_start_rd", bus.rd_en, 1'b0);

        // Tone width against sequence length (shortens only with the speed-up build)
        start_play(8);
        wait_done(200);
        check("t6_w_len8", last_w, tone_w(8));
        tick();
        start_play(4);
        wait_done(200);
        check("t6_w_len4", last_w, tone_w(4));
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
